// File: rtl/uart_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the UART register block (slave).
interface uart_axi_lite_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/uart_axi_lite_regs.sv
// AXI4-Lite register front end for the UART: RXDATA pops the Rx FIFO, TXDATA pushes the Tx FIFO,
// STATUS reports FIFO flags plus a sticky Tx-drop flag that clears when read.
module uart_axi_lite_regs #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int DBITS  = 8
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    uart_axi_lite_regs_if.slave  s_axi,
    output logic                 read_uart,
    input  logic [DBITS-1:0]     read_data,
    input  logic                 rx_empty,
    input  logic                 rx_full,
    output logic                 write_uart,
    output logic [DBITS-1:0]     write_data,
    input  logic                 tx_full
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_RXDATA  = 2'd0;
    localparam logic [1:0] REG_TXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;

    // Write channel holding registers: AW and W may arrive in any order.
    logic             aw_held_p0;
    logic [1:0]       aw_sel_p0;
    logic             w_held_p0;
    logic [DBITS-1:0] wdata_p0;
    logic             wstrb0_p0;

    // Response / pulse stage, visible one cycle after the accepting edge.
    logic              bvld_p1;
    logic [1:0]        bresp_p1;
    logic              rvld_p1;
    logic [1:0]        rresp_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              read_uart_p1;
    logic              write_uart_p1;
    logic [DBITS-1:0]  write_data_p1;
    logic              tx_drop;

    logic             aw_fire, w_fire, ar_fire;
    logic [1:0]       wr_sel, rd_sel;
    logic [DBITS-1:0] wr_word;
    logic             wr_strb0;
    logic             wr_exec, wr_mapped, wr_push, wr_drop;
    logic             rd_pop, rd_status_clr;
    logic [DATA_W-1:0] rd_data_nxt;
    logic [1:0]        rd_resp_nxt;
    logic              unused_bus_bits;

    function automatic logic [DATA_W-1:0] rxdata_word(input logic             empty,
                                                       input logic [DBITS-1:0] head);
        logic [DATA_W-1:0] w;
        w = '0;
        if (!empty) begin
            w[DBITS-1:0] = head;
            w[8]         = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] status_word(input logic empty, input logic full_rx,
                                                      input logic full_tx, input logic drop);
        logic [DATA_W-1:0] w;
        w      = '0;
        w[3:0] = {drop, full_tx, full_rx, ~empty};
        return w;
    endfunction

    assign s_axi.s_awready = ~aw_held_p0 & ~bvld_p1;
    assign s_axi.s_wready  = ~w_held_p0 & ~bvld_p1;
    assign s_axi.s_arready = ~rvld_p1;
    assign s_axi.s_bvalid  = bvld_p1;
    assign s_axi.s_bresp   = bresp_p1;
    assign s_axi.s_rvalid  = rvld_p1;
    assign s_axi.s_rresp   = rresp_p1;
    assign s_axi.s_rdata   = rdata_p1;
    assign read_uart       = read_uart_p1;
    assign write_uart      = write_uart_p1;
    assign write_data      = write_data_p1;

    assign unused_bus_bits = ^{s_axi.s_awaddr, s_axi.s_araddr, s_axi.s_wdata, s_axi.s_wstrb};

    // Write decode: held halves take priority over the live bus.
    assign aw_fire   = s_axi.s_awvalid & s_axi.s_awready;
    assign w_fire    = s_axi.s_wvalid & s_axi.s_wready;
    assign wr_sel    = aw_held_p0 ? aw_sel_p0 : s_axi.s_awaddr[3:2];
    assign wr_word   = w_held_p0 ? wdata_p0 : s_axi.s_wdata[DBITS-1:0];
    assign wr_strb0  = w_held_p0 ? wstrb0_p0 : s_axi.s_wstrb[0];
    assign wr_exec   = (aw_held_p0 | aw_fire) & (w_held_p0 | w_fire);
    assign wr_mapped = (wr_sel == REG_TXDATA);
    assign wr_push   = wr_exec & wr_mapped & wr_strb0 & ~tx_full;
    assign wr_drop   = wr_exec & wr_mapped & wr_strb0 & tx_full;

    // Read decode happens on the AR handshake cycle so the captured word matches the pop.
    assign ar_fire       = s_axi.s_arvalid & s_axi.s_arready;
    assign rd_sel        = s_axi.s_araddr[3:2];
    assign rd_pop        = ar_fire & (rd_sel == REG_RXDATA) & ~rx_empty;
    assign rd_status_clr = ar_fire & (rd_sel == REG_STATUS);

    always_comb begin
        rd_data_nxt = '0;
        rd_resp_nxt = RESP_OKAY;
        case (rd_sel)
            REG_RXDATA: rd_data_nxt = rxdata_word(rx_empty, read_data);
            REG_STATUS: rd_data_nxt = status_word(rx_empty, rx_full, tx_full, tx_drop);
            default:    rd_resp_nxt = RESP_SLVERR;
        endcase
    end

    // Stage p0: latch whichever write half arrives first.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            aw_held_p0 <= 1'b0;
            aw_sel_p0  <= 2'd0;
            w_held_p0  <= 1'b0;
            wdata_p0   <= '0;
            wstrb0_p0  <= 1'b0;
        end else if (wr_exec) begin
            aw_held_p0 <= 1'b0;
            w_held_p0  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held_p0 <= 1'b1;
                aw_sel_p0  <= s_axi.s_awaddr[3:2];
            end
            if (w_fire) begin
                w_held_p0 <= 1'b1;
                wdata_p0  <= s_axi.s_wdata[DBITS-1:0];
                wstrb0_p0 <= s_axi.s_wstrb[0];
            end
        end
    end

    // Stage p1: write response and Tx push pulse.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            bvld_p1       <= 1'b0;
            bresp_p1      <= RESP_OKAY;
            write_uart_p1 <= 1'b0;
            write_data_p1 <= '0;
        end else begin
            write_uart_p1 <= wr_push;
            if (wr_push) begin
                write_data_p1 <= wr_word;
            end
            if (wr_exec) begin
                bvld_p1  <= 1'b1;
                bresp_p1 <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (bvld_p1 && s_axi.s_bready) begin
                bvld_p1 <= 1'b0;
            end
        end
    end

    // Stage p1: read response and Rx pop pulse.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rvld_p1      <= 1'b0;
            rresp_p1     <= RESP_OKAY;
            rdata_p1     <= '0;
            read_uart_p1 <= 1'b0;
        end else begin
            read_uart_p1 <= rd_pop;
            if (ar_fire) begin
                rvld_p1  <= 1'b1;
                rresp_p1 <= rd_resp_nxt;
                rdata_p1 <= rd_data_nxt;
            end else if (rvld_p1 && s_axi.s_rready) begin
                rvld_p1 <= 1'b0;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a STATUS read wins.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tx_drop <= 1'b0;
        end else if (wr_drop) begin
            tx_drop <= 1'b1;
        end else if (rd_status_clr) begin
            tx_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_axi_lite_regs.sv
// Bench for uart_axi_lite_regs: vector table plus hand sequences, with response and pulse scoreboards.
module tb_uart_axi_lite_regs;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DBITS  = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic             clk_100MHz = 1'b0;
    logic             reset_n;
    logic             read_uart, write_uart;
    logic [DBITS-1:0] read_data, write_data;
    logic             rx_empty, rx_full, tx_full;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_axi_lite_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    uart_axi_lite_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBITS(DBITS)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .s_axi      (bus),
        .read_uart  (read_uart),
        .read_data  (read_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .tx_full    (tx_full)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  order;   // 0: AW+W together, 1: AW first, 2: W first
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rx_empty;
        logic        rx_full;
        logic        tx_full;
        logic [7:0]  rd;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_push;
        logic        exp_pop;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    rsp_t       exp_r_q[$];
    logic [1:0] exp_b_q[$];
    logic [7:0] exp_wd_q[$];
    int         exp_pops = 0;
    int         tests = 0;
    int         fails = 0;
    rsp_t       r_exp;
    logic [1:0] b_exp;
    logic [7:0] wd_exp;
    logic       prev_ru = 1'b0;
    logic       prev_wu = 1'b0;
    vec_t       vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] order, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic rxe, input logic rxf, input logic txf,
                                input logic [7:0] rd, input logic [1:0] resp,
                                input logic [31:0] rdata, input logic push, input logic pop);
        vec_t v;
        v.wr = wr; v.order = order; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.rx_empty = rxe; v.rx_full = rxf; v.tx_full = txf; v.rd = rd;
        v.exp_resp = resp; v.exp_rdata = rdata; v.exp_push = push; v.exp_pop = pop;
        return v;
    endfunction

    // Scoreboard side: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk_100MHz) begin
        if (reset_n) begin
            if (bus.s_rvalid && bus.s_rready) begin
                check("r_expected", exp_r_q.size() > 0, 1);
                if (exp_r_q.size() > 0) begin
                    r_exp = exp_r_q.pop_front();
                    check("rresp", bus.s_rresp, r_exp.resp);
                    check("rdata", bus.s_rdata, r_exp.data);
                end
            end
            if (bus.s_bvalid && bus.s_bready) begin
                check("b_expected", exp_b_q.size() > 0, 1);
                if (exp_b_q.size() > 0) begin
                    b_exp = exp_b_q.pop_front();
                    check("bresp", bus.s_bresp, b_exp);
                end
            end
            if (read_uart) begin
                check("pop_expected", exp_pops > 0, 1);
                check("read_uart_back2back", prev_ru, 0);
                if (exp_pops > 0) exp_pops--;
            end
            if (write_uart) begin
                check("push_expected", exp_wd_q.size() > 0, 1);
                check("write_uart_back2back", prev_wu, 0);
                if (exp_wd_q.size() > 0) begin
                    wd_exp = exp_wd_q.pop_front();
                    check("write_data", write_data, wd_exp);
                end
            end
        end
        prev_ru <= read_uart;
        prev_wu <= write_uart;
    end

    task automatic wait_responses(input string name);
        int n = 0;
        while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && n < 20) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        check({name, "_resp_timeout"}, n < 20, 1);
        check({name, "_pulses_done"}, exp_pops + exp_wd_q.size(), 0);
        exp_r_q.delete();
        exp_b_q.delete();
        exp_wd_q.delete();
        exp_pops = 0;
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int n = 0;
        rx_empty  = v.rx_empty;
        rx_full   = v.rx_full;
        tx_full   = v.tx_full;
        read_data = v.rd;
        if (v.exp_pop) exp_pops++;
        if (v.exp_push) exp_wd_q.push_back(v.wdata[7:0]);
        if (!v.wr) begin
            exp_r_q.push_back('{resp: v.exp_resp, data: v.exp_rdata});
            bus.s_araddr  = v.addr;
            bus.s_arvalid = 1'b1;
            while (!bus.s_arready && n < 20) begin
                @(posedge clk_100MHz); #1;
                n++;
            end
            @(posedge clk_100MHz); #1;
            bus.s_arvalid = 1'b0;
        end else begin
            exp_b_q.push_back(v.exp_resp);
            bus.s_awaddr  = v.addr;
            bus.s_wdata   = v.wdata;
            bus.s_wstrb   = v.wstrb;
            bus.s_awvalid = (v.order != 2'd2);
            bus.s_wvalid  = (v.order != 2'd1);
            @(posedge clk_100MHz); #1;
            bus.s_awvalid = (v.order == 2'd2);
            bus.s_wvalid  = (v.order == 2'd1);
            if (v.order != 2'd0) begin
                @(posedge clk_100MHz); #1;
                bus.s_awvalid = 1'b0;
                bus.s_wvalid  = 1'b0;
            end
        end
        wait_responses($sformatf("v%0d", idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_awaddr  = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0; bus.s_wstrb   = '0; bus.s_wvalid = 1'b0;
        bus.s_bready  = 1'b1;
        bus.s_araddr  = '0; bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b1;
        rx_empty = 1'b1; rx_full = 1'b0; tx_full = 1'b0; read_data = '0;
        reset_n  = 1'b0;

        //          wr ord addr  wdata          strb  rxe rxf txf rd     resp    rdata          push pop
        vecs[0]  = mk(0, 0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 8'h3C, OKAY,   32'h0000_013C, 0, 1);
        vecs[1]  = mk(0, 0, 4'h0, 32'h0,         4'h0, 1, 0, 0, 8'h3C, OKAY,   32'h0,         0, 0);
        vecs[2]  = mk(1, 0, 4'h4, 32'h0000_005A, 4'hF, 1, 0, 0, 8'h00, OKAY,   32'h0,         1, 0);
        vecs[3]  = mk(1, 2, 4'h4, 32'h0000_0077, 4'hE, 1, 0, 0, 8'h00, OKAY,   32'h0,         0, 0);
        vecs[4]  = mk(1, 0, 4'h4, 32'h0000_0011, 4'hF, 1, 0, 1, 8'h00, OKAY,   32'h0,         0, 0);
        vecs[5]  = mk(0, 0, 4'h8, 32'h0,         4'h0, 0, 0, 1, 8'h00, OKAY,   32'h0000_000D, 0, 0);
        vecs[6]  = mk(0, 0, 4'h8, 32'h0,         4'h0, 0, 0, 1, 8'h00, OKAY,   32'h0000_0005, 0, 0);
        vecs[7]  = mk(0, 0, 4'hC, 32'h0,         4'h0, 0, 1, 1, 8'h55, SLVERR, 32'h0,         0, 0);
        vecs[8]  = mk(0, 0, 4'h4, 32'h0,         4'h0, 0, 0, 0, 8'h55, SLVERR, 32'h0,         0, 0);
        vecs[9]  = mk(1, 0, 4'h0, 32'h0000_0022, 4'hF, 0, 0, 0, 8'h55, SLVERR, 32'h0,         0, 0);
        vecs[10] = mk(1, 1, 4'h8, 32'h0000_0033, 4'hF, 0, 0, 1, 8'h55, SLVERR, 32'h0,         0, 0);
        vecs[11] = mk(1, 2, 4'hC, 32'h0000_0044, 4'hF, 0, 0, 0, 8'h55, SLVERR, 32'h0,         0, 0);
        vecs[12] = mk(0, 0, 4'h2, 32'h0,         4'h0, 0, 0, 0, 8'hFF, OKAY,   32'h0000_01FF, 0, 1);
        vecs[13] = mk(1, 1, 4'h7, 32'hFFFF_FF33, 4'h1, 0, 0, 0, 8'h00, OKAY,   32'h0,         1, 0);
        vecs[14] = mk(0, 0, 4'h8, 32'h0,         4'h0, 0, 1, 0, 8'h00, OKAY,   32'h0000_0003, 0, 0);

        repeat (3) @(posedge clk_100MHz);
        #1;
        check("rst_bvalid", bus.s_bvalid, 0);
        check("rst_rvalid", bus.s_rvalid, 0);
        check("rst_bresp", bus.s_bresp, 0);
        check("rst_rresp", bus.s_rresp, 0);
        check("rst_rdata", bus.s_rdata, 0);
        check("rst_pulses", {read_uart, write_uart}, 0);
        check("rst_write_data", write_data, 0);
        check("rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        @(posedge clk_100MHz); #1;

        // AW one cycle ahead of W, B held off for three cycles.
        bus.s_bready = 1'b0;
        exp_b_q.push_back(OKAY);
        exp_wd_q.push_back(8'hA5);
        bus.s_awaddr  = 4'h4;
        bus.s_awvalid = 1'b1;
        @(posedge clk_100MHz); #1;
        bus.s_awvalid = 1'b0;
        check("aw_held_awready", bus.s_awready, 0);
        check("aw_held_wready", bus.s_wready, 1);
        check("aw_held_no_bvalid", bus.s_bvalid, 0);
        bus.s_wdata  = 32'h0000_00A5;
        bus.s_wstrb  = 4'hF;
        bus.s_wvalid = 1'b1;
        @(posedge clk_100MHz); #1;
        bus.s_wvalid = 1'b0;
        check("wr_bvalid_t1", bus.s_bvalid, 1);
        check("wr_write_uart_t1", write_uart, 1);
        check("wr_write_data_t1", write_data, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_100MHz); #1;
            check($sformatf("wr_bvalid_hold%0d", i), bus.s_bvalid, 1);
            check($sformatf("wr_no_repulse%0d", i), write_uart, 0);
        end
        bus.s_bready = 1'b1;
        @(posedge clk_100MHz); #1;
        check("wr_bvalid_cleared", bus.s_bvalid, 0);
        check("wr_awready_back", bus.s_awready, 1);
        wait_responses("hand_wr");

        for (int i = 0; i < 15; i++) begin
            do_txn(vecs[i], i);
        end

        // AR and AW+W in the same cycle.
        rx_empty = 1'b0; rx_full = 1'b0; tx_full = 1'b0; read_data = 8'h42;
        exp_r_q.push_back('{resp: OKAY, data: 32'h0000_0142});
        exp_b_q.push_back(OKAY);
        exp_wd_q.push_back(8'h99);
        exp_pops = 1;
        bus.s_araddr = 4'h0; bus.s_arvalid = 1'b1;
        bus.s_awaddr = 4'h4; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h0000_0099; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        @(posedge clk_100MHz); #1;
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("sim_pulses", {read_uart, write_uart}, 2'b11);
        check("sim_valids", {bus.s_rvalid, bus.s_bvalid}, 2'b11);
        wait_responses("sim");

        // Reset asserted right after an RXDATA AR handshake.
        rx_empty = 1'b0; read_data = 8'h66;
        bus.s_araddr = 4'h0; bus.s_arvalid = 1'b1;
        @(posedge clk_100MHz); #1;
        reset_n = 1'b0;
        bus.s_arvalid = 1'b0;
        #1;
        check("midrst_rvalid", bus.s_rvalid, 0);
        check("midrst_read_uart", read_uart, 0);
        check("midrst_rdata", bus.s_rdata, 0);
        check("midrst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_100MHz); #1;
            check($sformatf("postrst_quiet%0d", i),
                  {read_uart, write_uart, bus.s_rvalid, bus.s_bvalid}, 4'b0000);
        end
        check("postrst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_axi_lite_regs.md
# uart_axi_lite_regs

AXI4-Lite responder that exposes the UART core's Rx and Tx FIFOs to a bus master as a small memory-mapped register file. It sits between the system interconnect and the UART top level. It converts bus reads of the data register into single-cycle Rx FIFO pop pulses, and bus writes into single-cycle Tx FIFO push pulses with data. It also reports FIFO status and a sticky Tx-drop flag.

## Interface
- ADDR_W, 4, AXI address width; only addr[3:2] decoded, addr[1:0] ignored
- DATA_W, 32, AXI data width
- DBITS, 8, UART word width; must be ≤ DATA_W
- clk_100MHz  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid / s_awready  in / out  1  write address handshake
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  byte strobes
- s_wvalid / s_wready  in / out  1  write data handshake
- s_bresp  out  2  write response, OKAY=00, SLVERR=10
- s_bvalid / s_bready  out / in  1  write response handshake
- s_araddr  in  ADDR_W  read address
- s_arvalid / s_arready  in / out  1  read address handshake
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  read data handshake
- read_uart  out  1  Rx FIFO pop pulse
- read_data  in  DBITS  Rx FIFO head word, combinational from FIFO
- rx_empty, rx_full  in  1  Rx FIFO flags
- write_uart  out  1  Tx FIFO push pulse
- write_data  out  DBITS  Tx FIFO push word
- tx_full  in  1  Tx FIFO full flag; tie 0 if unused

## Operation
- Register map, by addr[3:2]:
  - 0 RXDATA (RO): rdata[DBITS-1:0]=head word, rdata[8]=valid (=~rx_empty at capture). Other bits 0.
  - 1 TXDATA (WO): push wdata[DBITS-1:0].
  - 2 STATUS (RO): [0] ~rx_empty, [1] rx_full, [2] tx_full, [3] tx_drop. Other bits 0.
  - 3: unmapped.
- RXDATA read with rx_empty=0 captures read_data and pops the FIFO once. With rx_empty=1: rdata=0, no pop, OKAY.
- TXDATA write with wstrb[0]=1 and tx_full=0 pushes once. With tx_full=1: no push, tx_drop set, OKAY. With wstrb[0]=0: no push, no flag, OKAY.
- tx_drop is sticky. Any STATUS read returns the current value, then clears it. A set and a clear in the same cycle resolves to set.
- Reads of TXDATA or addr 3, and writes to RXDATA, STATUS or addr 3: SLVERR, rdata=0, no side effects.
- Write channel: AW and W are accepted independently, in either order or together. Each is latched and held.
  - s_awready = ~aw_held & ~s_bvalid; s_wready = ~w_held & ~s_bvalid.
  - The write executes in the cycle both are held or arriving. The response then stays until the B handshake.
- Read channel: s_arready = ~s_rvalid. R holds until the R handshake.
- Read and write channels are fully independent; both may complete in the same cycle.

## Timing
- Reset (async assert, sync release): s_bvalid=0, s_rvalid=0, s_bresp=00, s_rresp=00, s_rdata=0, read_uart=0, write_uart=0, write_data=0, tx_drop=0, aw_held=0, w_held=0. Hence s_awready=1, s_wready=1, s_arready=1.
- A reset mid-transaction drops the transaction silently; no partial pulses after release.
- AR handshake in cycle T:
  - rdata, rresp and the valid bit are registered at the T edge.
  - s_rvalid=1 from T+1.
  - read_uart=1 during T+1 only.
  - The next AR is accepted no earlier than the cycle after the R handshake, so the pop always precedes the next capture.
- Write completes in cycle T (last of AW/W accepted):
  - s_bvalid=1 from T+1.
  - write_uart=1 during T+1 only, with write_data valid in T+1.
- Read latency and write latency are each 1 cycle. Back-to-back throughput is one transaction per 2 cycles per channel.
- read_uart and write_uart are never high for 2 consecutive cycles.

## Test plan
- Reset: hold reset_n=0 mid-AR -> all outputs at reset values. After release, s_arready=s_awready=s_wready=1 and no pulses.
- Write 0x0000_00A5 to 0x4 with tx_full=0, AW one cycle before W -> write_uart pulses once with write_data=0xA5. s_bvalid next cycle, bresp=00; bvalid held while bready=0 for 3 cycles.
- rx_empty=0, read_data=0x3C, read 0x0 -> rdata=0x0000_013C, rresp=00, exactly one read_uart pulse. With rx_empty=1 -> rdata=0, no pulse.
- tx_full=1, write 0x11 to 0x4 -> no write_uart pulse. STATUS read returns bit3=1; the second STATUS read returns bit3=0.
- Read 0xC and write 0x0 -> both SLVERR, no read_uart or write_uart pulses.
- Simultaneous AR to 0x0 and AW+W to 0x4 in the same cycle -> both pulses in the next cycle, both responses correct.
